// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

    // Data-memory access sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // Register r0 is hard-wired to zero and never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default parameter values for the top level
    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction currently in ID.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       lu
);

    // Writes to r0 are discarded, so they never cause a stall
    always_comb begin
        lu = idex_memread && (idex_rt != REG_ZERO) &&
             ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline: load-use stalls,
// taken-branch flushes, and a req/ack freeze for multi-cycle MEM accesses.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             BranchTaken_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             mem_ack_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_en_o,
    output logic             mem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o
);

    localparam int             TO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    mem_state_e       state_reg, state_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] lu_cnt_reg, mem_cnt_reg;

    logic mem_pending;
    logic freeze;
    logic lu;

    hazard_detect u_hazard_detect (
        .idex_memread (IDEX_MemRead_i),
        .idex_rt      (IDEX_Rt_i),
        .ifid_rs      (IFID_Rs_i),
        .ifid_rt      (IFID_Rt_i),
        .lu           (lu)
    );

    // Pipeline is frozen while a memory access is outstanding; the ack cycle
    // itself advances so EX/MEM can pick up the next instruction.
    always_comb begin
        mem_pending = EXMEM_MemRead_i || EXMEM_MemWrite_i;
        freeze      = ((state_reg == ST_IDLE) && mem_pending) ||
                      ((state_reg == ST_BUSY) && !mem_ack_i);
    end

    // Next-state logic for the access sequencer and its timeout watchdog
    always_comb begin
        state_next  = state_reg;
        to_cnt_next = to_cnt_reg;
        err_next    = err_reg;
        case (state_reg)
            ST_IDLE: begin
                // ack is meaningless without an outstanding request
                if (mem_pending) begin
                    state_next  = ST_BUSY;
                    to_cnt_next = '0;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_next = ST_IDLE;
                end else begin
                    // Saturate so a dead memory keeps err set without wrapping
                    if (to_cnt_reg != TO_LAST) begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                    if (to_cnt_next == TO_LAST) begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, watchdog and error flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            err_reg    <= err_next;
        end
    end

    // Stall performance counters; both wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_cnt_reg  <= '0;
            mem_cnt_reg <= '0;
        end else begin
            if (!freeze && lu) begin
                lu_cnt_reg <= lu_cnt_reg + CNT_W'(1);
            end
            if (freeze) begin
                mem_cnt_reg <= mem_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Output priority: reset > memory freeze > load-use > taken branch
    always_comb begin
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        pipe_en_o     = 1'b1;
        mem_req_o     = 1'b0;
        if (rst_i) begin
            PC_write_o   = 1'b0;
            IFID_write_o = 1'b0;
            pipe_en_o    = 1'b0;
        end else begin
            mem_req_o = ((state_reg == ST_IDLE) && mem_pending) ||
                        (state_reg == ST_BUSY);
            if (freeze) begin
                PC_write_o   = 1'b0;
                IFID_write_o = 1'b0;
                pipe_en_o    = 1'b0;
            end else if (lu) begin
                // Branch operands are not ready yet, so a taken branch waits
                PC_write_o    = 1'b0;
                IFID_write_o  = 1'b0;
                IDEX_bubble_o = 1'b1;
            end else if (BranchTaken_i) begin
                IFID_flush_o = 1'b1;
            end
        end
    end

    assign err_o           = err_reg;
    assign lu_stall_cnt_o  = lu_cnt_reg;
    assign mem_stall_cnt_o = mem_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             idex_rd;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             br;
    logic             exmem_rd;
    logic             exmem_wr;
    logic             ack;
    logic             pc_w;
    logic             ifid_w;
    logic             ifid_fl;
    logic             idex_bub;
    logic             pipe_en;
    logic             mem_req;
    logic             err;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mem_cnt;

    int checks = 0;
    int errors = 0;
    int lu_exp  = 0;
    int mem_exp = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .IDEX_MemRead_i   (idex_rd),
        .IDEX_Rt_i        (idex_rt),
        .IFID_Rs_i        (ifid_rs),
        .IFID_Rt_i        (ifid_rt),
        .BranchTaken_i    (br),
        .EXMEM_MemRead_i  (exmem_rd),
        .EXMEM_MemWrite_i (exmem_wr),
        .mem_ack_i        (ack),
        .PC_write_o       (pc_w),
        .IFID_write_o     (ifid_w),
        .IFID_flush_o     (ifid_fl),
        .IDEX_bubble_o    (idex_bub),
        .pipe_en_o        (pipe_en),
        .mem_req_o        (mem_req),
        .err_o            (err),
        .lu_stall_cnt_o   (lu_cnt),
        .mem_stall_cnt_o  (mem_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic [4:0] rt_ex;
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       brt;
        logic       e_pc;
        logic       e_ifw;
        logic       e_fl;
        logic       e_bub;
        logic       e_pe;
        int         e_inc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare all single-bit controls at once
    task automatic chk_ctl(input string tag, input logic e_pc, input logic e_ifw,
                           input logic e_fl, input logic e_bub, input logic e_pe,
                           input logic e_req);
        chk({tag, ".PC_write"},    {31'd0, pc_w},     {31'd0, e_pc});
        chk({tag, ".IFID_write"},  {31'd0, ifid_w},   {31'd0, e_ifw});
        chk({tag, ".IFID_flush"},  {31'd0, ifid_fl},  {31'd0, e_fl});
        chk({tag, ".IDEX_bubble"}, {31'd0, idex_bub}, {31'd0, e_bub});
        chk({tag, ".pipe_en"},     {31'd0, pipe_en},  {31'd0, e_pe});
        chk({tag, ".mem_req"},     {31'd0, mem_req},  {31'd0, e_req});
        $display("%s: pc=%b ifw=%b fl=%b bub=%b pe=%b req=%b err=%b lu=%0d mem=%0d",
                 tag, pc_w, ifid_w, ifid_fl, idex_bub, pipe_en, mem_req, err, lu_cnt, mem_cnt);
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        idex_rd = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; br = 1'b0;
    endtask

    initial begin
        //         rd rtEX rsID rtID br  pc ifw fl bub pe inc
        vecs[0] = '{1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[3] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        vecs[5] = '{1'b1, 5'd9, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[6] = '{1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};

        // Reset: all controls forced low even with a pending access
        clr_id();
        exmem_rd = 1'b1; exmem_wr = 1'b0; ack = 1'b0; rst = 1'b1;
        cycle_end();
        @(negedge clk);
        chk_ctl("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.err", {31'd0, err}, 32'd0);
        cycle_end();
        rst = 1'b0; exmem_rd = 1'b0;
        @(negedge clk);
        chk_ctl("post_reset", 1, 1, 0, 0, 1, 0);
        chk("post_reset.lu_cnt", lu_cnt, 32'd0);
        chk("post_reset.mem_cnt", mem_cnt, 32'd0);
        cycle_end();

        // Single-cycle hazard/branch vectors
        for (int i = 0; i < 8; i++) begin
            idex_rd = vecs[i].rd; idex_rt = vecs[i].rt_ex;
            ifid_rs = vecs[i].rs_id; ifid_rt = vecs[i].rt_id; br = vecs[i].brt;
            @(negedge clk);
            chk_ctl($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifw, vecs[i].e_fl,
                    vecs[i].e_bub, vecs[i].e_pe, 1'b0);
            cycle_end();
            lu_exp += vecs[i].e_inc;
            chk($sformatf("vec%0d.lu_cnt", i), lu_cnt, lu_exp);
            chk($sformatf("vec%0d.mem_cnt", i), mem_cnt, mem_exp);
        end
        clr_id();

        // Load acked on the 4th BUSY cycle; hazard+branch raised while frozen
        exmem_rd = 1'b1;
        @(negedge clk);
        chk_ctl("ld_req", 0, 0, 0, 0, 0, 1);
        mem_exp++;
        cycle_end();
        for (int b = 1; b <= 3; b++) begin
            if (b == 2) begin
                idex_rd = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3; br = 1'b1;
            end
            @(negedge clk);
            chk_ctl($sformatf("ld_busy%0d", b), 0, 0, 0, 0, 0, 1);
            mem_exp++;
            cycle_end();
        end
        ack = 1'b1;
        @(negedge clk);
        chk_ctl("ld_ack", 0, 0, 0, 1, 1, 1);
        lu_exp++;
        cycle_end();
        ack = 1'b0; exmem_rd = 1'b0; clr_id();
        @(negedge clk);
        chk_ctl("ld_done", 1, 1, 0, 0, 1, 0);
        chk("ld_done.mem_cnt", mem_cnt, mem_exp);
        chk("ld_done.lu_cnt", lu_cnt, lu_exp);
        cycle_end();

        // Back-to-back store then load; req must never drop
        exmem_wr = 1'b1;
        @(negedge clk);
        chk_ctl("b2b_st_req", 0, 0, 0, 0, 0, 1);
        cycle_end();
        @(negedge clk);
        chk_ctl("b2b_st_busy", 0, 0, 0, 0, 0, 1);
        cycle_end();
        ack = 1'b1;
        @(negedge clk);
        chk_ctl("b2b_st_ack", 1, 1, 0, 0, 1, 1);
        cycle_end();
        // Now IDLE again: ack held high must be ignored
        exmem_wr = 1'b0; exmem_rd = 1'b1;
        @(negedge clk);
        chk_ctl("b2b_ld_req", 0, 0, 0, 0, 0, 1);
        cycle_end();
        ack = 1'b0;
        @(negedge clk);
        chk_ctl("b2b_ld_busy", 0, 0, 0, 0, 0, 1);
        cycle_end();
        ack = 1'b1;
        @(negedge clk);
        chk_ctl("b2b_ld_ack", 1, 1, 0, 0, 1, 1);
        cycle_end();
        ack = 1'b0; exmem_rd = 1'b0;
        mem_exp += 4;
        @(negedge clk);
        chk_ctl("b2b_done", 1, 1, 0, 0, 1, 0);
        chk("b2b_done.mem_cnt", mem_cnt, mem_exp);
        cycle_end();

        // Timeout with MEM_TIMEOUT=8: err after 7 un-acked BUSY cycles
        exmem_rd = 1'b1;
        @(negedge clk);
        chk_ctl("to_req", 0, 0, 0, 0, 0, 1);
        mem_exp++;
        cycle_end();
        for (int b = 1; b <= 10; b++) begin
            @(negedge clk);
            chk($sformatf("to_busy%0d.err", b), {31'd0, err}, (b >= 8) ? 32'd1 : 32'd0);
            chk_ctl($sformatf("to_busy%0d", b), 0, 0, 0, 0, 0, 1);
            mem_exp++;
            cycle_end();
        end
        ack = 1'b1;
        @(negedge clk);
        chk_ctl("to_ack", 1, 1, 0, 0, 1, 1);
        cycle_end();
        ack = 1'b0; exmem_rd = 1'b0;
        @(negedge clk);
        chk_ctl("to_done", 1, 1, 0, 0, 1, 0);
        chk("to_done.err", {31'd0, err}, 32'd1);
        chk("to_done.mem_cnt", mem_cnt, mem_exp);
        cycle_end();

        // Reset in the middle of BUSY abandons the access
        exmem_rd = 1'b1;
        cycle_end();
        @(negedge clk);
        chk_ctl("rb_busy", 0, 0, 0, 0, 0, 1);
        cycle_end();
        rst = 1'b1;
        idex_rd = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; br = 1'b1;
        @(negedge clk);
        chk_ctl("rb_rst", 0, 0, 0, 0, 0, 0);
        cycle_end();
        rst = 1'b0; exmem_rd = 1'b0; clr_id();
        @(negedge clk);
        chk_ctl("rb_after", 1, 1, 0, 0, 1, 0);
        chk("rb_after.err", {31'd0, err}, 32'd0);
        chk("rb_after.lu_cnt", lu_cnt, 32'd0);
        chk("rb_after.mem_cnt", mem_cnt, 32'd0);
        cycle_end();
        idex_rd = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        @(negedge clk);
        chk_ctl("rb_lu", 0, 0, 0, 1, 1, 0);
        cycle_end();
        clr_id();
        chk("rb_lu.lu_cnt", lu_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
